// File: rtl/tlul_host_seq_pkg.sv
// Shared types for tlul_host_seq: FSM states, latched request and timeout fill data.
package tlul_host_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } seq_state_e;

    localparam logic [31:0] TimeoutData = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } seq_req_t;

    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL type package: channel structs, opcodes and the A-channel integrity fold.
package tlul_pkg;

    localparam int unsigned TL_AW  = 32;
    localparam int unsigned TL_DW  = 32;
    localparam int unsigned TL_AIW = 8;
    localparam int unsigned TL_DIW = 1;
    localparam int unsigned TL_DBW = 4;
    localparam int unsigned TL_SZW = 2;

    localparam logic [3:0] InstrTypeData = 4'h9;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [4:0] rsvd;
        logic [3:0] instr_type;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic                a_valid;
        tl_a_op_e            a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        tl_a_user_t          a_user;
        logic                d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                d_valid;
        tl_d_op_e            d_opcode;
        logic [2:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic [TL_DIW-1:0]   d_sink;
        logic [TL_DW-1:0]    d_data;
        tl_d_user_t          d_user;
        logic                d_error;
        logic                a_ready;
    } tl_d2h_t;

    // Seven interleaved parity lanes over a 64-bit payload.
    function automatic logic [6:0] intg_fold(input logic [63:0] v);
        logic [6:0] f;
        f = '0;
        for (int unsigned b = 0; b < 7; b++) begin
            for (int unsigned i = b; i < 64; i += 7) begin
                f[b] = f[b] ^ v[i];
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/tlul_cmd_intg_gen.sv
// Fills a_user command/data integrity fields of an outgoing TL-UL A-channel request.
module tlul_cmd_intg_gen
    import tlul_pkg::*;
(
    input  tl_h2d_t tl_i,
    output tl_h2d_t tl_o
);

    logic [63:0] cmd_payload;
    logic [63:0] data_payload;

    assign cmd_payload  = {21'd0, tl_i.a_user.instr_type, tl_i.a_address,
                           tl_i.a_opcode, tl_i.a_mask};
    assign data_payload = {32'd0, tl_i.a_data};

    always_comb begin
        tl_o                    = tl_i;
        tl_o.a_user.cmd_intg    = intg_fold(cmd_payload);
        tl_o.a_user.data_intg   = intg_fold(data_payload);
    end

endmodule

// File: rtl/tlul_host_rr_arb.sv
// Round-robin arbiter: one-hot grant while enabled; priority moves past the winner on grant.
module tlul_host_rr_arb #(
    parameter int unsigned NumReq = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [NumReq-1:0]         req,
    output logic [NumReq-1:0]         gnt,
    output logic [$clog2(NumReq)-1:0] idx
);

    localparam int unsigned IdxW = $clog2(NumReq);

    logic [IdxW-1:0] ptr;
    logic            found;
    int unsigned     cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = (32'(ptr) + i) % NumReq;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IdxW'(cand);
            end
        end
        if (!en) begin
            gnt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en && found) begin
            ptr <= (idx == IdxW'(NumReq - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/tlul_host_seq.sv
// Single-outstanding TL-UL host sequencer sharing one device port between NumReq requesters.
// Optional D-channel watchdog enabled by defining TLUL_HOST_SEQ_TIMEOUT_EN.
module tlul_host_seq
    import tlul_host_seq_pkg::*;
#(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumReq-1:0]      req_i,
    input  logic [NumReq-1:0]      we_i,
    input  logic [NumReq*32-1:0]   addr_i,
    input  logic [NumReq*32-1:0]   wdata_i,
    input  logic [NumReq*4-1:0]    be_i,
    output logic [NumReq-1:0]      gnt_o,
    output logic [NumReq-1:0]      rvalid_o,
    output logic [31:0]            rdata_o,
    output logic                   err_o,
    output logic                   busy_o,
    output tlul_pkg::tl_h2d_t      tl_h2d_o,
    input  tlul_pkg::tl_d2h_t      tl_d2h_i
);

    localparam int unsigned IdxW = $clog2(NumReq);

    seq_state_e        state, state_next;
    seq_req_t          cur, sel;
    logic [IdxW-1:0]   cur_idx, arb_idx;
    logic [NumReq-1:0] arb_gnt;
    logic              arb_en;
    logic              rsp_take;
    logic              timeout;
    logic [NumReq-1:0] rvalid;
    logic [31:0]       rdata;
    logic              err;
    tlul_pkg::tl_h2d_t tl_raw;
    logic              unused_d2h;

    tlul_host_rr_arb #(
        .NumReq(NumReq)
    ) u_arb (
        .clk  (clk_i),
        .rst_n(rst_ni),
        .en   (arb_en),
        .req  (req_i),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );

    // Reads are normalised at latch time so the A channel needs no per-cycle muxing.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (arb_gnt[i]) begin
                sel.we    = we_i[i];
                sel.addr  = word_addr(addr_i[i*32 +: 32]);
                sel.be    = we_i[i] ? be_i[i*4 +: 4] : 4'hf;
                sel.wdata = we_i[i] ? wdata_i[i*32 +: 32] : '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        arb_en     = 1'b0;
        unique case (state)
            IDLE: begin
                arb_en = 1'b1;
                if (|req_i) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (tl_d2h_i.a_ready) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (tl_d2h_i.d_valid || timeout) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur     <= '0;
            cur_idx <= '0;
        end else if (state == IDLE && |req_i) begin
            cur     <= sel;
            cur_idx <= arb_idx;
        end
    end

`ifdef TLUL_HOST_SEQ_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt <= '0;
        end else if (state == ADDR) begin
            tmo_cnt <= '0;
        end else if (state == DATA) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign timeout = (state == DATA) && !tl_d2h_i.d_valid &&
                     (tmo_cnt == 16'(TimeoutCycles - 1));
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TimeoutCycles;
    assign timeout        = 1'b0;
`endif

    // d_valid outside DATA (including the a_ready cycle) is intentionally ignored.
    assign rsp_take = (state == DATA) && tl_d2h_i.d_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid <= '0;
            rdata  <= '0;
            err    <= 1'b0;
        end else begin
            rvalid <= '0;
            if (rsp_take) begin
                rvalid <= {{(NumReq-1){1'b0}}, 1'b1} << cur_idx;
                rdata  <= tl_d2h_i.d_data;
                err    <= tl_d2h_i.d_error || (tl_d2h_i.d_source != 8'(cur_idx));
            end else if (timeout) begin
                rvalid <= {{(NumReq-1){1'b0}}, 1'b1} << cur_idx;
                rdata  <= TimeoutData;
                err    <= 1'b1;
            end
        end
    end

    always_comb begin
        tl_raw                   = '0;
        tl_raw.a_valid           = (state == ADDR);
        tl_raw.a_opcode          = cur.we ? tlul_pkg::PutFullData : tlul_pkg::Get;
        tl_raw.a_param           = '0;
        tl_raw.a_size            = 2'd2;
        tl_raw.a_source          = 8'(cur_idx);
        tl_raw.a_address         = cur.addr;
        tl_raw.a_mask            = cur.be;
        tl_raw.a_data            = cur.wdata;
        tl_raw.a_user.instr_type = tlul_pkg::InstrTypeData;
        tl_raw.d_ready           = 1'b1;
    end

    tlul_cmd_intg_gen u_intg_gen (
        .tl_i(tl_raw),
        .tl_o(tl_h2d_o)
    );

    assign unused_d2h = ^{tl_d2h_i.d_opcode, tl_d2h_i.d_param, tl_d2h_i.d_size,
                          tl_d2h_i.d_sink, tl_d2h_i.d_user};

    assign gnt_o    = arb_gnt;
    assign rvalid_o = rvalid;
    assign rdata_o  = rdata;
    assign err_o    = err;
    assign busy_o   = (state != IDLE);

endmodule

// File: tb/tb_tlul_host_seq.sv
// Directed self-checking bench for tlul_host_seq with a hand-driven TL-UL device.
module tb_tlul_host_seq;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic [1:0]        req, we;
    logic [63:0]       addr, wdata;
    logic [7:0]        be;
    logic [1:0]        gnt, rvalid;
    logic [31:0]       rdata;
    logic              err, busy;
    tlul_pkg::tl_h2d_t h2d;
    tlul_pkg::tl_d2h_t d2h;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tlul_host_seq #(
        .NumReq       (2),
        .TimeoutCycles(16)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .req_i   (req),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .be_i    (be),
        .gnt_o   (gnt),
        .rvalid_o(rvalid),
        .rdata_o (rdata),
        .err_o   (err),
        .busy_o  (busy),
        .tl_h2d_o(h2d),
        .tl_d2h_i(d2h)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_d();
        d2h         = '0;
        d2h.a_ready = 1'b1;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while (busy === 1'b1 && n < 50) begin
            tick();
            n++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_idle: busy=%b required 0 within 50 cycles", busy);
        end
    endtask

    // Raise req in IDLE, capture the grant, then drop the granted line after the edge.
    task automatic request(input logic [1:0] r, output logic [1:0] g);
        wait_idle();
        req = r;
        #1;
        g = gnt;
        tick();
        req = req & ~g;
    endtask

    // Called in ADDR with a_ready=1: one cycle to DATA, then a single-cycle response.
    task automatic respond(input logic [31:0] data, input logic [7:0] src, input logic derr,
                           output logic [1:0] rv, output logic [31:0] rd, output logic e);
        tick();
        d2h.d_valid  = 1'b1;
        d2h.d_opcode = tlul_pkg::AccessAckData;
        d2h.d_data   = data;
        d2h.d_source = src;
        d2h.d_error  = derr;
        tick();
        idle_d();
        rv = rvalid;
        rd = rdata;
        e  = err;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0; be = '0;
        idle_d();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (gnt !== 2'b00)   begin n_bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        n_cmp++; if (rvalid !== 2'b00) begin n_bad++; $display("FAIL reset_rvalid: got %b want 00", rvalid); end
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        n_cmp++; if (err !== 1'b0)    begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (h2d.a_valid !== 1'b0) begin n_bad++; $display("FAIL reset_a_valid: got %b want 0", h2d.a_valid); end
        n_cmp++; if (h2d.d_ready !== 1'b1) begin n_bad++; $display("FAIL reset_d_ready: got %b want 1", h2d.d_ready); end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_read();
        logic [1:0] g, rv; logic [31:0] rd; logic e;
        we = 2'b00; addr[31:0] = 32'h0000_0013; be[3:0] = 4'h0; wdata[31:0] = 32'hFFFF_FFFF;
        request(2'b01, g);
        n_cmp++; if (g !== 2'b01) begin n_bad++; $display("FAIL read_gnt: got %b want 01", g); end
        n_cmp++; if (h2d.a_valid !== 1'b1) begin n_bad++; $display("FAIL read_a_valid: got %b want 1", h2d.a_valid); end
        n_cmp++; if (h2d.a_opcode !== tlul_pkg::Get) begin n_bad++; $display("FAIL read_opcode: got %0h want 4", h2d.a_opcode); end
        n_cmp++; if (h2d.a_address !== 32'h10) begin n_bad++; $display("FAIL read_addr: got %h want 10", h2d.a_address); end
        n_cmp++; if (h2d.a_mask !== 4'hf) begin n_bad++; $display("FAIL read_mask: got %h want f", h2d.a_mask); end
        n_cmp++; if (h2d.a_data !== 32'h0) begin n_bad++; $display("FAIL read_data: got %h want 0", h2d.a_data); end
        n_cmp++; if (h2d.a_size !== 2'd2) begin n_bad++; $display("FAIL read_size: got %0d want 2", h2d.a_size); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL read_busy: got %b want 1", busy); end
        respond(32'h1234_5678, 8'd0, 1'b0, rv, rd, e);
        n_cmp++; if (rv !== 2'b01) begin n_bad++; $display("FAIL read_rvalid: got %b want 01", rv); end
        n_cmp++; if (rd !== 32'h1234_5678) begin n_bad++; $display("FAIL read_rdata: got %h want 12345678", rd); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL read_err: got %b want 0", e); end
        tick();
        n_cmp++; if (rvalid !== 2'b00) begin n_bad++; $display("FAIL read_rvalid_pulse: got %b want 00", rvalid); end
    endtask

    task automatic test_write();
        logic [1:0] g, rv; logic [31:0] rd; logic e;
        we = 2'b10; addr[63:32] = 32'h8; wdata[63:32] = 32'h2; be[7:4] = 4'h3;
        request(2'b10, g);
        n_cmp++; if (g !== 2'b10) begin n_bad++; $display("FAIL write_gnt: got %b want 10", g); end
        n_cmp++; if (h2d.a_opcode !== tlul_pkg::PutFullData) begin n_bad++; $display("FAIL write_opcode: got %0h want 0", h2d.a_opcode); end
        n_cmp++; if (h2d.a_source !== 8'd1) begin n_bad++; $display("FAIL write_source: got %0d want 1", h2d.a_source); end
        n_cmp++; if (h2d.a_mask !== 4'h3) begin n_bad++; $display("FAIL write_mask: got %h want 3", h2d.a_mask); end
        n_cmp++; if (h2d.a_data !== 32'h2) begin n_bad++; $display("FAIL write_data: got %h want 2", h2d.a_data); end
        n_cmp++; if (h2d.a_address !== 32'h8) begin n_bad++; $display("FAIL write_addr: got %h want 8", h2d.a_address); end
        respond(32'h0, 8'd1, 1'b0, rv, rd, e);
        n_cmp++; if (rv !== 2'b10) begin n_bad++; $display("FAIL write_rvalid: got %b want 10", rv); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL write_err: got %b want 0", e); end
    endtask

    task automatic test_arbitration();
        logic [1:0] g, rv, exp; logic [31:0] rd; logic e;
        we = 2'b00;
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            request(2'b11, g);
            n_cmp++; if (g !== exp) begin n_bad++; $display("FAIL arb_gnt%0d: got %b want %b", k, g, exp); end
            n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL arb_hold%0d: got %b want 00", k, gnt); end
            respond(32'h100 + 32'(k), 8'(k % 2), 1'b0, rv, rd, e);
            if (k == 3) req = 2'b00;
            n_cmp++; if (rv !== exp) begin n_bad++; $display("FAIL arb_rvalid%0d: got %b want %b", k, rv, exp); end
            n_cmp++; if (rd !== 32'h100 + 32'(k)) begin n_bad++; $display("FAIL arb_rdata%0d: got %h want %h", k, rd, 32'h100 + 32'(k)); end
        end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL arb_dropped_req: busy=%b want 0", busy); end
    endtask

    task automatic test_error();
        logic [1:0] g, rv; logic [31:0] rd; logic e;
        we = 2'b00;
        request(2'b01, g);
        respond(32'hA5A5_A5A5, 8'd0, 1'b1, rv, rd, e);
        n_cmp++; if (rv !== 2'b01 || e !== 1'b1) begin n_bad++; $display("FAIL err_derror: rvalid=%b err=%b want 01/1", rv, e); end
        request(2'b01, g);
        n_cmp++; if (g !== 2'b01) begin n_bad++; $display("FAIL err_b2b_gnt: got %b want 01", g); end
        respond(32'h5A5A_5A5A, 8'd1, 1'b0, rv, rd, e);
        n_cmp++; if (rv !== 2'b01 || e !== 1'b1) begin n_bad++; $display("FAIL err_source: rvalid=%b err=%b want 01/1", rv, e); end
    endtask

    task automatic test_stall_reset();
        logic [1:0] g, rv; logic [31:0] rd; logic e;
        we = 2'b00; addr[63:32] = 32'h0000_0104;
        d2h.a_ready = 1'b0;
        request(2'b10, g);
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (h2d.a_valid !== 1'b1 || h2d.a_address !== 32'h104 || h2d.a_opcode !== tlul_pkg::Get ||
                h2d.a_mask !== 4'hf || h2d.a_source !== 8'd1 || h2d.a_data !== 32'h0) begin
                n_bad++;
                $display("FAIL stall_cycle%0d: valid=%b addr=%h mask=%h src=%0d want 1/104/f/1", c,
                         h2d.a_valid, h2d.a_address, h2d.a_mask, h2d.a_source);
            end
            tick();
        end
        d2h.a_ready = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b1 || h2d.a_valid !== 1'b0) begin n_bad++; $display("FAIL stall_data: busy=%b a_valid=%b want 1/0", busy, h2d.a_valid); end
        d2h.d_valid = 1'b1; d2h.d_data = 32'h7777_7777; d2h.d_source = 8'd1;
        #1 rst_ni = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || h2d.a_valid !== 1'b0 || rvalid !== 2'b00 || err !== 1'b0 || rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL midreset: busy=%b a_valid=%b rvalid=%b err=%b rdata=%h want all 0", busy, h2d.a_valid, rvalid, err, rdata);
        end
        tick();
        rst_ni = 1'b1;
        idle_d();
        tick();
        n_cmp++; if (rvalid !== 2'b00) begin n_bad++; $display("FAIL midreset_drop: rvalid=%b want 00", rvalid); end
        addr[63:32] = 32'h20;
        request(2'b10, g);
        n_cmp++; if (g !== 2'b10 || h2d.a_address !== 32'h20) begin n_bad++; $display("FAIL postreset_req: gnt=%b addr=%h want 10/20", g, h2d.a_address); end
        respond(32'hCAFE_F00D, 8'd1, 1'b0, rv, rd, e);
        n_cmp++; if (rv !== 2'b10 || rd !== 32'hCAFE_F00D || e !== 1'b0) begin
            n_bad++; $display("FAIL postreset_rsp: rvalid=%b rdata=%h err=%b want 10/cafef00d/0", rv, rd, e);
        end
    endtask

    task automatic test_stray();
        logic [1:0] g;
        d2h.d_valid = 1'b1; d2h.d_data = 32'h0BAD;
        tick();
        idle_d();
        n_cmp++; if (rvalid !== 2'b00) begin n_bad++; $display("FAIL stray_idle: rvalid=%b want 00", rvalid); end
        we = 2'b00; addr[31:0] = 32'h40;
        request(2'b01, g);
        d2h.d_valid = 1'b1; d2h.d_data = 32'h1111; d2h.d_source = 8'd0;
        tick();
        idle_d();
        n_cmp++; if (rvalid !== 2'b00 || busy !== 1'b1) begin n_bad++; $display("FAIL zero_lat_drop: rvalid=%b busy=%b want 00/1", rvalid, busy); end
        tick();
        n_cmp++; if (rvalid !== 2'b00 || busy !== 1'b1) begin n_bad++; $display("FAIL zero_lat_wait: rvalid=%b busy=%b want 00/1", rvalid, busy); end
        d2h.d_valid = 1'b1; d2h.d_data = 32'h2222; d2h.d_source = 8'd0;
        tick();
        idle_d();
        n_cmp++; if (rvalid !== 2'b01 || rdata !== 32'h2222) begin n_bad++; $display("FAIL zero_lat_rsp: rvalid=%b rdata=%h want 01/2222", rvalid, rdata); end
    endtask

    task automatic test_timeout();
        logic [1:0] g;
        int unsigned n;
        we = 2'b00; addr[31:0] = 32'h80;
        request(2'b01, g);
        n = 0;
`ifdef TLUL_HOST_SEQ_TIMEOUT_EN
        while (n < 40) begin
            tick();
            n++;
            if (rvalid !== 2'b00) break;
        end
        n_cmp++; if (n != 17) begin n_bad++; $display("FAIL timeout_latency: rvalid after %0d cycles want 17", n); end
        n_cmp++; if (rvalid !== 2'b01 || err !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL timeout_rsp: rvalid=%b err=%b rdata=%h want 01/1/deadbeef", rvalid, err, rdata);
        end
        d2h.d_valid = 1'b1; d2h.d_data = 32'h3333;
        tick();
        idle_d();
        n_cmp++; if (rvalid !== 2'b00 || busy !== 1'b0) begin n_bad++; $display("FAIL timeout_late: rvalid=%b busy=%b want 00/0", rvalid, busy); end
`else
        while (n < 40) begin
            tick();
            n++;
        end
        n_cmp++; if (busy !== 1'b1 || rvalid !== 2'b00) begin n_bad++; $display("FAIL no_timeout_wait: busy=%b rvalid=%b want 1/00", busy, rvalid); end
        d2h.d_valid = 1'b1; d2h.d_data = 32'h5555; d2h.d_source = 8'd0;
        tick();
        idle_d();
        n_cmp++; if (rvalid !== 2'b01 || rdata !== 32'h5555 || err !== 1'b0) begin
            n_bad++; $display("FAIL no_timeout_rsp: rvalid=%b rdata=%h err=%b want 01/5555/0", rvalid, rdata, err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_arbitration();
        test_error();
        test_stall_reset();
        test_stray();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
